// File: rtl/maple_hub.sv
// maple_hub: multi-port Maple bus capture hub feeding the FX2 EP6 slave FIFO.
//
// Each Maple port owns a byte ring buffer and a small queue of committed frame
// lengths. A round-robin arbiter picks a port with a committed frame. The
// output FSM then writes a 4-byte header followed by the payload into EP6.
//
// Ports:
//   clk       system clock (also FX2 IFCLK)
//   reset     synchronous, active-low
//   menable   per port, high while a frame is in progress
//   mready    per port, one-cycle strobe qualifying mdata
//   mdata     per port byte, port i on [8i+7:8i]
//   flagd     EP6 full flag, active-low
//   fdata     FIFO data bus (write only)
//   faddr     FIFO address, fixed to EP6
//   sloe/slrd read controls, held inactive
//   slwr      active-low write strobe
//   pkt_end   active-low packet commit
//   ovf       sticky per-port overflow (frame truncated or dropped)
module maple_hub #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 512,
    parameter int FRAMES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   menable,
    input  logic [CHANNELS-1:0]   mready,
    input  logic [8*CHANNELS-1:0] mdata,
    input  logic                  flagd,
    output logic [7:0]            fdata,
    output logic [1:0]            faddr,
    output logic                  sloe,
    output logic                  slrd,
    output logic                  slwr,
    output logic                  pkt_end,
    output logic [CHANNELS-1:0]   ovf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [QW:0] Q_FULL = (QW + 1)'(FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_END} state_t;

    // Length-queue index increment; explicit wrap keeps FRAMES=1 legal.
    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (p == QW'(FRAMES - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [CHANNELS-1:0]        avail;
    logic [CHANNELS-1:0]        pop;
    logic [CHANNELS-1:0]        adv;
    logic [CHANNELS-1:0][16:0]  q_head;
    logic [CHANNELS-1:0][7:0]   rd_byte;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic          men_q, men_d;
            logic          active_q, active_d;
            logic [15:0]   len_q, len_d;
            logic          trunc_q, trunc_d;
            logic          ovf_q, ovf_d;
            logic [AW:0]   wr_ptr_q, wr_ptr_d;
            logic [AW:0]   rd_ptr_q, rd_ptr_d;
            logic [QW-1:0] qwr_q, qwr_d, qrd_q, qrd_d;
            logic [QW:0]   qcnt_q, qcnt_d;
            logic          avail_q, avail_d;
            logic          rise, fall, buf_full, we, push;
            logic [7:0]    rd_data_q;
            logic [7:0]    mem [DEPTH];
            logic [16:0]   lq  [FRAMES];

            // Occupancy from the start of the cycle: equal indices, differing wrap bit.
            assign buf_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

            always_comb begin
                rise     = menable[gi] & ~men_q;
                fall     = active_q & ~menable[gi];
                men_d    = menable[gi];
                active_d = active_q;
                len_d    = len_q;
                trunc_d  = trunc_q;
                ovf_d    = ovf_q;
                wr_ptr_d = wr_ptr_q;
                we       = 1'b0;
                push     = 1'b0;
                if (rise) begin
                    if (qcnt_q == Q_FULL) begin
                        // No room to commit: the whole frame is ignored.
                        ovf_d = 1'b1;
                    end else begin
                        active_d = 1'b1;
                        len_d    = '0;
                        trunc_d  = 1'b0;
                    end
                end else if (fall) begin
                    active_d = 1'b0;
                    push     = (len_q != '0);
                end
                // A byte may arrive in the same cycle as the rising edge.
                if (active_d && menable[gi] && mready[gi]) begin
                    if (buf_full) begin
                        trunc_d = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        len_d    = len_d + 16'd1;
                    end
                end
                qwr_d    = push ? q_inc(qwr_q) : qwr_q;
                qrd_d    = pop[gi] ? q_inc(qrd_q) : qrd_q;
                case ({push, pop[gi]})
                    2'b10:   qcnt_d = qcnt_q + 1'b1;
                    2'b01:   qcnt_d = qcnt_q - 1'b1;
                    default: qcnt_d = qcnt_q;
                endcase
                // Registered so a commit reaches the arbiter one cycle after landing.
                avail_d  = (qcnt_q != '0);
                rd_ptr_d = adv[gi] ? rd_ptr_q + 1'b1 : rd_ptr_q;
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    // Treat menable as already high so a frame in progress at
                    // release is skipped until its next rising edge.
                    men_q    <= 1'b1;
                    active_q <= 1'b0;
                    len_q    <= '0;
                    trunc_q  <= 1'b0;
                    ovf_q    <= 1'b0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    qwr_q    <= '0;
                    qrd_q    <= '0;
                    qcnt_q   <= '0;
                    avail_q  <= 1'b0;
                end else begin
                    men_q    <= men_d;
                    active_q <= active_d;
                    len_q    <= len_d;
                    trunc_q  <= trunc_d;
                    ovf_q    <= ovf_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    qwr_q    <= qwr_d;
                    qrd_q    <= qrd_d;
                    qcnt_q   <= qcnt_d;
                    avail_q  <= avail_d;
                end
            end

            // Read at the next pointer so the registered byte tracks rd_ptr_q
            // and the payload can stream at one byte per cycle.
            always_ff @(posedge clk) begin
                if (we) mem[wr_ptr_q[AW-1:0]] <= mdata[8*gi +: 8];
                rd_data_q <= mem[rd_ptr_d[AW-1:0]];
                if (push) lq[qwr_q] <= {trunc_q, len_q};
            end

            assign avail[gi]   = avail_q;
            assign q_head[gi]  = lq[qrd_q];
            assign rd_byte[gi] = rd_data_q;
            assign ovf[gi]     = ovf_q;
        end
    endgenerate

    state_t        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d, last_q, last_d, grant_ch;
    logic [15:0]   pk_len_q, pk_len_d;
    logic          pk_trunc_q, pk_trunc_d;
    logic [1:0]    hdr_idx_q, hdr_idx_d;
    logic [7:0]    fdata_q, fdata_d;
    logic          slwr_q, slwr_d, pkt_end_q, pkt_end_d, found;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        last_d     = last_q;
        pk_len_d   = pk_len_q;
        pk_trunc_d = pk_trunc_q;
        hdr_idx_d  = hdr_idx_q;
        fdata_d    = fdata_q;
        slwr_d     = 1'b1;
        pkt_end_d  = 1'b1;
        pop        = '0;
        adv        = '0;
        found      = 1'b0;
        grant_ch   = '0;
        // Search starts just after the last channel served.
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!found && avail[(int'(last_q) + k) % CHANNELS]) begin
                found    = 1'b1;
                grant_ch = CW'((int'(last_q) + k) % CHANNELS);
            end
        end
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ch_d                     = grant_ch;
                    last_d                   = grant_ch;
                    pop[grant_ch]            = 1'b1;
                    {pk_trunc_d, pk_len_d}   = q_head[grant_ch];
                    hdr_idx_d                = 2'd0;
                    state_d                  = S_HDR;
                end
            end
            S_HDR: begin
                if (flagd) begin
                    slwr_d    = 1'b0;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    case (hdr_idx_q)
                        2'd0:    fdata_d = 8'hA5;
                        2'd1:    fdata_d = {pk_trunc_q, 4'b0000, 3'(ch_q)};
                        2'd2:    fdata_d = pk_len_q[15:8];
                        default: begin
                            fdata_d = pk_len_q[7:0];
                            state_d = S_PAYLOAD;
                        end
                    endcase
                end
            end
            S_PAYLOAD: begin
                // pk_len_q now counts the payload bytes still to send.
                if (flagd) begin
                    slwr_d      = 1'b0;
                    fdata_d     = rd_byte[ch_q];
                    adv[ch_q]   = 1'b1;
                    pk_len_d    = pk_len_q - 16'd1;
                    if (pk_len_q == 16'd1) state_d = S_END;
                end
            end
            S_END: begin
                pkt_end_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            last_q     <= CW'(CHANNELS - 1);
            pk_len_q   <= '0;
            pk_trunc_q <= 1'b0;
            hdr_idx_q  <= '0;
            fdata_q    <= 8'h00;
            slwr_q     <= 1'b1;
            pkt_end_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            pk_len_q   <= pk_len_d;
            pk_trunc_q <= pk_trunc_d;
            hdr_idx_q  <= hdr_idx_d;
            fdata_q    <= fdata_d;
            slwr_q     <= slwr_d;
            pkt_end_q  <= pkt_end_d;
        end
    end

    assign fdata   = fdata_q;
    assign slwr    = slwr_q;
    assign pkt_end = pkt_end_q;
    assign faddr   = 2'b10;
    assign sloe    = 1'b1;
    assign slrd    = 1'b1;
endmodule

// File: tb/tb_maple_hub.sv
// Testbench for maple_hub (CHANNELS=2, DEPTH=16, FRAMES=4).
// A negedge monitor records every written byte (and 256 for each pkt_end
// cycle) with its cycle number; the stimulus compares that stream to packets
// built from hand-written vectors.
module tb_maple_hub;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  menable = '0;
    logic [1:0]  mready = '0;
    logic [15:0] mdata = '0;
    logic        flagd = 1'b1;
    logic [7:0]  fdata;
    logic [1:0]  faddr;
    logic        sloe, slrd, slwr, pkt_end;
    logic [1:0]  ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int got[$];
    int got_cyc[$];
    logic flagd_prev = 1'b1;

    typedef struct {
        int port;
        int n;
        int base;
        int step;
        int exp_b1;
        int exp_len;
        int exp_ovf;
    } vec_t;

    maple_hub #(.CHANNELS(2), .DEPTH(16), .FRAMES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .menable (menable),
        .mready  (mready),
        .mdata   (mdata),
        .flagd   (flagd),
        .fdata   (fdata),
        .faddr   (faddr),
        .sloe    (sloe),
        .slrd    (slrd),
        .slwr    (slwr),
        .pkt_end (pkt_end),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic int take();
        void'(got_cyc.pop_front());
        return got.pop_front();
    endfunction

    always @(negedge clk) begin
        if (!slwr) begin
            chk("slwr_after_flagd", int'(flagd_prev), 1);
            got.push_back(int'(fdata));
            got_cyc.push_back(cyc);
        end
        if (!pkt_end) begin
            chk("pkt_end_slwr_high", int'(slwr), 1);
            got.push_back(256);
            got_cyc.push_back(cyc);
        end
        flagd_prev = flagd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame on every port in mask; port p byte k = base + 64*p + k*step.
    task automatic send(input logic [1:0] mask, input int n, input int base,
                        input int step, output int fall_cyc);
        menable = menable | mask;
        tick();
        for (int k = 0; k < n; k++) begin
            for (int p = 0; p < 2; p++) mdata[8*p +: 8] = 8'(base + p * 64 + k * step);
            mready = mask;
            tick();
            mready = '0;
            tick();
        end
        menable  = menable & ~mask;
        fall_cyc = cyc;
        tick();
    endtask

    task automatic wait_got(input int n, input string nm);
        for (int i = 0; i < 500 && got.size() < n; i++) tick();
        if (got.size() < n) chk({nm, "_timeout"}, got.size(), n);
    endtask

    task automatic expect_pkt(input string nm, input int port, input int b1,
                              input int len, input int base, input int step);
        wait_got(len + 5, nm);
        if (got.size() < len + 5) begin
            got.delete();
            got_cyc.delete();
            return;
        end
        chk({nm, "_sync"}, take(), 'hA5);
        chk({nm, "_byte1"}, take(), b1);
        chk({nm, "_len_hi"}, take(), len >> 8);
        chk({nm, "_len_lo"}, take(), len & 255);
        for (int k = 0; k < len; k++)
            chk($sformatf("%s_data%0d", nm, k), take(), (base + port * 64 + k * step) & 255);
        chk({nm, "_pkt_end"}, take(), 256);
        $display("packet %s: port %0d, %0d payload bytes", nm, port, len);
    endtask

    initial begin
        int   fc;
        int   sz0;
        vec_t tbl [5];

        tbl[0] = '{1,  1, 'h5A, 1, 'h01,  1, 0};
        tbl[1] = '{0, 16, 'h00, 3, 'h00, 16, 0};
        tbl[2] = '{1,  4, 'hF0, 5, 'h01,  4, 0};
        tbl[3] = '{0,  2, 'h80, 1, 'h00,  2, 0};
        tbl[4] = '{1, 15, 'h10, 2, 'h01, 15, 0};

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        #1;
        chk("rst_slwr", int'(slwr), 1);
        chk("rst_pkt_end", int'(pkt_end), 1);
        chk("rst_sloe", int'(sloe), 1);
        chk("rst_slrd", int'(slrd), 1);
        chk("rst_faddr", int'(faddr), 2);
        chk("rst_fdata", int'(fdata), 0);
        chk("rst_ovf", int'(ovf), 0);
        tick();
        reset = 1'b1;
        tick();

        // Fairness: simultaneous commits, port0 first both times
        send(2'b11, 2, 'h01, 1, fc);
        expect_pkt("fair_a0", 0, 'h00, 2, 'h01, 1);
        expect_pkt("fair_a1", 1, 'h01, 2, 'h01, 1);
        send(2'b11, 3, 'h09, 2, fc);
        expect_pkt("fair_b0", 0, 'h00, 3, 'h09, 2);
        expect_pkt("fair_b1", 1, 'h01, 3, 'h09, 2);

        // Single frame with latency and back-to-back byte timing
        send(2'b01, 3, 'h11, 'h11, fc);
        wait_got(8, "lat");
        if (got_cyc.size() >= 8) begin
            chk("lat_first_hdr", got_cyc[0] - fc, 4);
            for (int i = 1; i < 8; i++)
                chk($sformatf("lat_gap%0d", i), got_cyc[i] - got_cyc[i-1], 1);
        end
        expect_pkt("single", 0, 'h00, 3, 'h11, 'h11);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            send(2'(1 << tbl[v].port), tbl[v].n, tbl[v].base, tbl[v].step, fc);
            expect_pkt($sformatf("vec%0d", v), tbl[v].port, tbl[v].exp_b1,
                       tbl[v].exp_len, tbl[v].base, tbl[v].step);
            chk($sformatf("vec%0d_ovf", v), int'(ovf), tbl[v].exp_ovf);
        end

        // Backpressure: 5-cycle stall mid-payload
        send(2'b10, 10, 'h20, 7, fc);
        for (int i = 0; i < 200 && got.size() < 6; i++) tick();
        flagd = 1'b0;
        @(negedge clk);
        #1;
        sz0 = got.size();
        repeat (5) tick();
        flagd = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_no_slwr_in_stall", got.size() - sz0, 0);
        expect_pkt("bp", 1, 'h01, 10, 'h20, 7);

        // Truncation (20 bytes into 16) with output stalled
        flagd = 1'b0;
        send(2'b01, 20, 'h30, 1, fc);
        repeat (2) tick();
        chk("trunc_ovf", int'(ovf), 1);
        // Queue full on port1 while port0's packet is stalled
        for (int j = 0; j < 5; j++) begin
            send(2'b10, 1, 'h61 + j, 1, fc);
            chk($sformatf("qfull_ovf%0d", j), int'(ovf), (j == 4) ? 3 : 1);
        end
        chk("stall_quiet", got.size(), 0);
        flagd = 1'b1;
        expect_pkt("trunc", 0, 'h80, 16, 'h30, 1);
        for (int j = 0; j < 4; j++)
            expect_pkt($sformatf("qfull%0d", j), 1, 'h01, 1, 'h61 + j, 1);

        // Reset mid-payload
        send(2'b01, 8, 'h40, 1, fc);
        for (int i = 0; i < 200 && got.size() < 6; i++) tick();
        reset   = 1'b0;
        menable = 2'b10;
        tick();
        @(negedge clk);
        #1;
        chk("midrst_slwr", int'(slwr), 1);
        chk("midrst_pkt_end", int'(pkt_end), 1);
        chk("midrst_fdata", int'(fdata), 0);
        chk("midrst_ovf", int'(ovf), 0);
        got.delete();
        got_cyc.delete();
        tick();
        reset = 1'b1;
        // Port1 menable already high at release: this frame is ignored
        tick();
        mdata  = 16'h5500;
        mready = 2'b10;
        tick();
        mready = '0;
        tick();
        menable = '0;
        repeat (30) tick();
        chk("rst_quiet", got.size(), 0);

        // Empty menable pulse and mready without menable
        menable = 2'b01;
        repeat (3) tick();
        menable = '0;
        tick();
        mdata  = 16'h7700;
        mready = 2'b10;
        tick();
        mready = '0;
        repeat (30) tick();
        chk("zero_len_quiet", got.size(), 0);

        send(2'b10, 3, 'h05, 1, fc);
        expect_pkt("post_rst", 1, 'h01, 3, 'h05, 1);
        chk("final_ovf", int'(ovf), 0);
        repeat (20) tick();
        chk("trailing_quiet", got.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/maple_hub.md
# maple_hub

Parametrised multi-port Maple bus capture hub. Per-port receivers deliver bytes on menable/mready/mdata strobes. The hub buffers each port's frames independently and round-robin arbitrates completed frames into the FX2 EP6 slave FIFO, prefixing each frame with a 4-byte header. It replaces the single-port receiver-to-FIFO path in the capture top level.

## Interface
- CHANNELS, 2: number of Maple ports, 1..8.
- DEPTH, 512: per-channel payload buffer in bytes; power of 2, at most 32768.
- FRAMES, 4: per-channel committed-frame length queue entries; power of 2.
- clk  in  1  system clock, also the FX2 IFCLK. One clock; reset is synchronous and active-low.
- reset  in  1  synchronous, active-low reset.
- menable  in  CHANNELS  per port; high while a Maple frame is in progress.
- mready  in  CHANNELS  per port; one-cycle strobe, mdata byte valid.
- mdata  in  8*CHANNELS  per port byte; port i occupies [8i+7:8i].
- flagd  in  1  EP6 full flag, active-low (0 = full).
- fdata  out  8  FX2 data bus, write direction only.
- faddr  out  2  FIFO address; constant 2'b10 (EP6).
- sloe, slrd  out  1  each; held 1 (reads unused).
- slwr  out  1  active-low write strobe.
- pkt_end  out  1  active-low packet commit.
- ovf  out  CHANNELS  sticky; a frame was truncated or dropped on that port.

## Operation
- **Capture, per channel:**
  - A frame starts on the menable rising edge.
  - If the length queue is full at that moment, the entire frame is dropped: no bytes are stored and ovf[i] is set.
  - Each mready pulse while menable=1 stores mdata and increments the length counter.
  - When the data buffer is full, further bytes are discarded. The frame's trunc bit is set, and so is ovf[i].
  - On the menable falling edge, {trunc, len} is pushed to the length queue. Zero-length frames are discarded silently.
  - mready while menable=0 is ignored.
- **Arbitration:**
  - The search starts at the channel after the last one served. After reset the pointer selects channel 0 first.
  - The first channel with a non-empty length queue wins. Its queue entry is popped on grant.
- **Output FSM:** IDLE -> HDR -> PAYLOAD -> END -> IDLE.
  - IDLE: grants when any queue is non-empty.
  - HDR: emits 4 bytes:
    - 0xA5
    - {trunc, 4'b0, ch[2:0]}
    - len[15:8]
    - len[7:0]
  - PAYLOAD: emits len bytes from the channel buffer, in arrival order.
  - END: pulses pkt_end low for one cycle, then returns to IDLE.
- Length counts stored bytes only, after truncation.
- Buffer pointers wrap modulo DEPTH. Full/empty is resolved with an extra pointer bit.
- A byte stored in the same cycle as a buffer read is legal. Full is evaluated against the pre-cycle occupancy.
- A commit lands in the queue one cycle after the menable falling edge and is visible to arbitration the cycle after that.

## Timing
- **Reset values:**
  - slwr=1, pkt_end=1, sloe=1, slrd=1, faddr=2'b10, fdata=8'h00, ovf=0.
  - All pointers, queues and counters cleared; FSM in IDLE; arbitration pointer selects channel 0.
- **Reset mid-operation:**
  - All buffered and in-flight frames are lost.
  - Any partially sent packet gets no pkt_end.
  - A port whose menable is already high at reset release does not capture until its next rising edge.
- **Write strobe:**
  - slwr=0 for exactly one cycle per byte, with fdata stable in that same cycle.
  - slwr is asserted only in a cycle where flagd=1 was sampled in the previous cycle.
  - If flagd=0, the FSM stalls holding the current byte, with slwr=1.
  - Throughput is 1 byte/cycle when not stalled.
- **Latency:**
  - The first header byte is written 2 cycles after the commit becomes visible, with the FSM idle and flagd=1.
  - pkt_end=0 occurs in the cycle after the last payload slwr, with slwr=1. pkt_end is not gated by flagd.
- Back-to-back packets: the next grant happens in the cycle after END.

## Test plan
- **Single frame:** CHANNELS=2; port0 sends 0x11,0x22,0x33 with flagd=1 -> writes A5,00,00,03,11,22,33 on 7 consecutive slwr-low cycles, then pkt_end low for 1 cycle.
- **Fairness:** frames committed on port0 and port1 in the same cycle -> port0 packet first (byte1=0x00), then port1 (byte1=0x01); the next simultaneous pair serves port0 first again, because the round-robin pointer has rotated back to it.
- **Backpressure:** flagd=0 for 5 cycles in mid-payload -> no slwr pulses during the stall; the byte sequence is unchanged and none are duplicated.
- **Truncation:** DEPTH=16; a 20-byte frame with the output stalled (flagd=0) -> header byte1=0x80, length 0x0010, the first 16 bytes sent, ovf[0]=1.
- **Queue full:** FRAMES=4; five 1-byte frames while flagd=0 -> the fifth frame is dropped, ovf set, 4 packets emitted after flagd=1.
- **Reset and zero-length:** reset asserted mid-payload -> outputs return to reset values next cycle, no pkt_end; an empty menable pulse -> nothing emitted.
